// File: rtl/alu_pkg.sv
// Shared types and packing helpers for the adder result buffer.
// Result word layout, MSB first: {id, carry, sum}.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_STALL
    } state_e;

    localparam int SUM_LSB = 0;

    function automatic int res_w(input int ds, input int ids);
        return ds + 1 + ids;
    endfunction

    function automatic int carry_pos(input int ds);
        return ds;
    endfunction

    function automatic int id_lsb(input int ds);
        return ds + 1;
    endfunction

endpackage

// File: rtl/out_alu_fifo.sv
// Synchronous FIFO holding packed adder results.
// Depth must be a power of two so the pointers wrap naturally.
module out_alu_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Full blocks a push even when a pop happens in the same cycle.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; empty masking is done by the consumer.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/out_alu.sv
// Output stage of the adder: captures results into a FIFO and acks them.
// Optional OUT_ALU_RES_COUNT_EN adds a 16-bit wrapping push counter.
module out_alu
    import alu_pkg::*;
#(
    parameter int DATA_SIZE  = 16,
    parameter int ID_SIZE    = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int RES_W = res_w(DATA_SIZE, ID_SIZE),
    localparam int CW    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid_res,
    input  logic [RES_W-1:0]     result_add,
    output logic                 ready_f_res,
    output logic                 sum_written,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ID_SIZE-1:0]   out_id,
    output logic                 out_carry,
    output logic [DATA_SIZE-1:0] out_sum
`ifdef OUT_ALU_RES_COUNT_EN
    ,
    output logic [15:0]          res_count
`endif
);

    localparam int CARRY_POS = carry_pos(DATA_SIZE);
    localparam int ID_LSB    = id_lsb(DATA_SIZE);

    state_e           state_q, state_d;
    logic             push, pop;
    logic             full, empty;
    logic [CW-1:0]    count;
    logic [RES_W-1:0] rdata, head;

    // Ack is a pure function of state: no comb path from a_valid_res.
    always_comb begin
        state_d     = state_q;
        push        = 1'b0;
        sum_written = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (a_valid_res && !full) begin
                    push    = 1'b1;
                    state_d = ST_ACK;
                end else if (a_valid_res) begin
                    state_d = ST_STALL;
                end
            end
            ST_ACK: begin
                sum_written = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_STALL: begin
                if (!full) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset drops any un-acked capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    out_alu_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (result_add),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign ready_f_res = !full;
    assign out_valid   = (count != '0);
    assign pop         = out_valid && out_ready;

    // Head unpacking; stale storage is hidden while empty.
    always_comb begin
        head      = empty ? '0 : rdata;
        out_sum   = head[SUM_LSB +: DATA_SIZE];
        out_carry = head[CARRY_POS];
        out_id    = head[ID_LSB +: ID_SIZE];
    end

`ifdef OUT_ALU_RES_COUNT_EN
    logic [15:0] res_count_q, res_count_d;

    // Counts accepted pushes, wrapping at 16 bits.
    always_comb begin
        res_count_d = res_count_q + 16'(push);
    end

    // Push counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_count_q <= '0;
        end else begin
            res_count_q <= res_count_d;
        end
    end

    assign res_count = res_count_q;
`endif

endmodule

// File: tb/tb_out_alu.sv
// Directed self-checking bench for out_alu.
// Inputs change and outputs are sampled on the falling edge.
module tb_out_alu;

    localparam int DS = 16;
    localparam int IS = 4;
    localparam int RW = DS + 1 + IS;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid_res;
    logic [RW-1:0] result_add;
    logic          ready_f_res;
    logic          sum_written;
    logic          out_valid;
    logic          out_ready;
    logic [IS-1:0] out_id;
    logic          out_carry;
    logic [DS-1:0] out_sum;
`ifdef OUT_ALU_RES_COUNT_EN
    logic [15:0]   res_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    out_alu #(
        .DATA_SIZE  (DS),
        .ID_SIZE    (IS),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid_res (a_valid_res),
        .result_add  (result_add),
        .ready_f_res (ready_f_res),
        .sum_written (sum_written),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_id      (out_id),
        .out_carry   (out_carry),
        .out_sum     (out_sum)
`ifdef OUT_ALU_RES_COUNT_EN
        ,
        .res_count   (res_count)
`endif
    );

    task automatic step();
        @(negedge clk);
    endtask

    // Adder model: hold the result until the ack is seen, then release.
    task automatic send(input logic [3:0] id, input logic c,
                        input logic [15:0] s, output int lat);
        result_add  = {id, c, s};
        a_valid_res = 1'b1;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!sum_written && lat < 20);
        n_tests++;
        if (sum_written !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ack id=%0d sum_written=%b want 1", id, sum_written);
        end
        a_valid_res = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_valid_res = 1'b0;
        out_ready = 1'b0;
        result_add = '0;
        step();
        step();
        n_tests++;
        if (out_valid !== 1'b0 || ready_f_res !== 1'b1 || sum_written !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags v=%b r=%b sw=%b want 0 1 0",
                     out_valid, ready_f_res, sum_written);
        end
        n_tests++;
        if (out_id !== 4'h0 || out_carry !== 1'b0 || out_sum !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_head id=%h c=%b s=%h want 0 0 0",
                     out_id, out_carry, out_sum);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        int lat;
        send(4'h1, 1'b1, 16'hFFFF, lat);
        n_tests++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL single_latency got %0d want 1", lat);
        end
        n_tests++;
        if (out_valid !== 1'b1 || out_id !== 4'h1 || out_carry !== 1'b1 || out_sum !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL single_head v=%b id=%h c=%b s=%h want 1 1 1 ffff",
                     out_valid, out_id, out_carry, out_sum);
        end
        step();
        n_tests++;
        if (sum_written !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pulse sw=%b v=%b want 0 1", sum_written, out_valid);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || out_sum !== 16'h0) begin
            n_fail++;
            $display("FAIL single_pop v=%b s=%h want 0 0000", out_valid, out_sum);
        end
    endtask

    task automatic test_fill_stall();
        int lat;
        int k;
        for (int i = 0; i < 4; i++) begin
            send(4'(i), i[0], 16'hA000 + 16'(i), lat);
        end
        n_tests++;
        if (ready_f_res !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full ready=%b want 0", ready_f_res);
        end
        result_add = {4'h4, 1'b0, 16'hA004};
        a_valid_res = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (sum_written !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_no_ack cyc=%0d sw=%b want 0", i, sum_written);
            end
        end
        n_tests++;
        if (out_id !== 4'h0) begin
            n_fail++;
            $display("FAIL stall_head id=%h want 0", out_id);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        k = 0;
        while (!sum_written && k < 10) begin
            step();
            k++;
        end
        n_tests++;
        if (sum_written !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release sw=%b want 1", sum_written);
        end
        a_valid_res = 1'b0;
        for (int i = 1; i < 5; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_id !== 4'(i) || out_carry !== i[0]
                || out_sum !== 16'hA000 + 16'(i)) begin
                n_fail++;
                $display("FAIL drain_%0d v=%b id=%h c=%b s=%h want 1 %h %b %h",
                         i, out_valid, out_id, out_carry, out_sum,
                         4'(i), i[0], 16'hA000 + 16'(i));
            end
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty v=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [3:0] id;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            id = 4'(i + 14);
            send(id, ~i[0], 16'(i * 3), lat);
            n_tests++;
            if (lat != (i == 0 ? 1 : 2) || ready_f_res !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_rate i=%0d lat=%0d ready=%b want %0d 1",
                         i, lat, ready_f_res, (i == 0 ? 1 : 2));
            end
            n_tests++;
            if (out_valid !== 1'b1 || out_id !== id || out_sum !== 16'(i * 3)) begin
                n_fail++;
                $display("FAIL b2b_head i=%0d v=%b id=%h s=%h want 1 %h %h",
                         i, out_valid, out_id, out_sum, id, 16'(i * 3));
            end
        end
        step();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_empty v=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        send(4'h5, 1'b0, 16'h0555, lat);
        send(4'h6, 1'b1, 16'h0666, lat);
        send(4'h7, 1'b0, 16'h0777, lat);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || sum_written !== 1'b0 || ready_f_res !== 1'b1
            || out_id !== 4'h0) begin
            n_fail++;
            $display("FAIL midrst v=%b sw=%b r=%b id=%h want 0 0 1 0",
                     out_valid, sum_written, ready_f_res, out_id);
        end
        send(4'h9, 1'b0, 16'h1234, lat);
        n_tests++;
        if (lat != 1 || out_id !== 4'h9 || out_sum !== 16'h1234) begin
            n_fail++;
            $display("FAIL midrst_next lat=%0d id=%h s=%h want 1 9 1234",
                     lat, out_id, out_sum);
        end
`ifdef OUT_ALU_RES_COUNT_EN
        n_tests++;
        if (res_count !== 16'h0001) begin
            n_fail++;
            $display("FAIL res_count got %h want 0001", res_count);
        end
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_pop v=%b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_stall();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/out_alu.md
OUT_ALU -- requirements
Module: out_alu

Interface
REQ-001 Parameter DATA_SIZE, 16, operand/sum width of the producing adder.
REQ-002 Parameter ID_SIZE, 4, transaction ID width.
REQ-003 Parameter FIFO_DEPTH, 4, result buffer entries; power of two, at least 2.
REQ-004 Local RES_W = DATA_SIZE+1+ID_SIZE; result packing {id, carry, sum}, MSB first.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 a_valid_res  input  1  adder holds a valid result; held until sum_written seen.
REQ-008 result_add  input  RES_W  packed result, stable while a_valid_res=1.
REQ-009 ready_f_res  output  1  buffer has room for one result.
REQ-010 sum_written  output  1  one-cycle pulse: result captured, adder may release.
REQ-011 out_valid  output  1  buffer non-empty.
REQ-012 out_ready  input  1  downstream pops head when out_valid=1.
REQ-013 out_id  output  ID_SIZE  head entry ID field.
REQ-014 out_carry  output  1  head entry carry field.
REQ-015 out_sum  output  DATA_SIZE  head entry sum field.

Function
REQ-016 FSM states IDLE, ACK, STALL; state register only, no combinational path from a_valid_res to sum_written.
REQ-017 IDLE: a_valid_res=1 and not full -> push result_add this cycle, next ACK; a_valid_res=1 and full -> STALL; else stay IDLE.
REQ-018 ACK: sum_written=1 for exactly this cycle; no push; next IDLE unconditionally.
REQ-019 STALL: no push; next IDLE when not full (push then taken from IDLE); stays STALL while full.
REQ-020 sum_written=0 in IDLE and STALL.
REQ-021 ready_f_res = not full, derived from registered occupancy.
REQ-022 Capture latency: push in cycle T -> sum_written=1 and entry visible (out_valid=1 if previously empty) in cycle T+1.
REQ-023 Pop occurs when out_valid=1 and out_ready=1; out_ready ignored when empty.
REQ-024 Push and pop in same cycle: both performed, occupancy unchanged; push while full never occurs (full blocks push even if pop in same cycle).
REQ-025 Occupancy counter width clog2(FIFO_DEPTH)+1; read/write pointers wrap modulo FIFO_DEPTH.
REQ-026 Ordering strictly FIFO; out_id/out_carry/out_sum unpack head entry combinationally from buffer.
REQ-027 Minimum back-to-back rate: one result per two cycles (IDLE->ACK).

Reset
REQ-028 rst=1 at a rising edge: state IDLE, occupancy 0, pointers 0; after that edge sum_written=0, out_valid=0, ready_f_res=1, out_id/out_carry/out_sum=0.
REQ-029 Reset mid-operation (any state, any occupancy) discards all buffered entries; a pending un-acknowledged result is not acknowledged.
REQ-030 Buffer storage contents need no reset; outputs are forced to 0 while empty.

Configuration
REQ-031 Macro OUT_ALU_RES_COUNT_EN defined: extra output res_count [15:0], incremented on each push, wraps 0xFFFF->0x0000, reset to 0.
REQ-032 Macro undefined: port res_count and its counter absent; all other behaviour identical.

Structure
REQ-033 Package alu_pkg holds the FSM state enum, RES_W computation, and field offset constants for {id, carry, sum}.
REQ-034 One sub-module out_alu_fifo (synchronous FIFO, push/pop/full/empty/count); FSM and unpacking stay in out_alu.

Verification
REQ-035 Reset: assert rst 2 cycles -> out_valid=0, ready_f_res=1, sum_written=0.
REQ-036 Single result 0x1_1_FFFF (id=1, carry=1, sum=0xFFFF), out_ready=0 -> sum_written pulses 1 cycle at T+1; out_id=1, out_carry=1, out_sum=0xFFFF.
REQ-037 Five results, out_ready=0, FIFO_DEPTH=4 -> four acknowledged, ready_f_res=0, fifth held in STALL with sum_written=0; pop one -> fifth acknowledged, order ids 0..4 preserved on drain.
REQ-038 Continuous push every 2 cycles with out_ready=1 -> occupancy never exceeds 1, no stall, ids wrap 15->0 correctly.
REQ-039 rst asserted in ACK with 3 entries -> after edge out_valid=0, sum_written=0, next result stored at pointer 0.
REQ-040 With OUT_ALU_RES_COUNT_EN, 65537 pushes -> res_count=0x0001.
